// File: rtl/matrix_pkg.sv
// Shared types and width/index helpers for the parametrised matrix multiplier.
package matrix_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  function automatic int unsigned ceil_log2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((33'd1 << i) < 33'(v)) r = 32'(i + 1);
    end
    return r;
  endfunction

  // Row counter width; never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (ceil_log2(v) == 0) ? 32'd1 : ceil_log2(v);
  endfunction

  // Full-precision dot-product width: 2W product bits plus growth for N terms.
  function automatic int unsigned acc_w(input int unsigned n, input int unsigned w);
    return 2 * w + ceil_log2(n);
  endfunction

  function automatic int unsigned idx(input int unsigned r, input int unsigned c,
                                      input int unsigned n, input int unsigned w);
    return (r * n + c) * w;
  endfunction

endpackage

// File: rtl/matrix_mult_param_if.sv
// Handshake and matrix bus between the register file side and the multiplier.
interface matrix_mult_param_if #(
  parameter int unsigned N = 5,
  parameter int unsigned W = 8
) ();
  logic               start;
  logic               sat_mode;
  logic [N*N*W-1:0]   matriz_a;
  logic [N*N*W-1:0]   matriz_b;
  logic [N*N*W-1:0]   matriz_c;
  logic               busy;
  logic               done;
  logic               overflow;

  modport master (
    output start, sat_mode, matriz_a, matriz_b,
    input  matriz_c, busy, done, overflow
  );

  modport slave (
    input  start, sat_mode, matriz_a, matriz_b,
    output matriz_c, busy, done, overflow
  );
endinterface

// File: rtl/matrix_dot_sat.sv
// One output element: full-precision signed dot product, then wrap or clamp to W bits.
module matrix_dot_sat
  import matrix_pkg::*;
#(
  parameter int unsigned N = 5,
  parameter int unsigned W = 8
) (
  input  logic [N*W-1:0] a_row,
  input  logic [N*W-1:0] b_col,
  input  logic           sat_mode,
  output logic [W-1:0]   elem,
  output logic           oor
);
  localparam int unsigned ACC_W = acc_w(N, W);
  localparam int unsigned PW    = 2 * W;
  localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};

  logic signed [ACC_W-1:0] acc;
  logic signed [PW-1:0]    prod;

  // Exact sum; no truncation until the final conversion.
  always_comb begin
    acc  = '0;
    prod = '0;
    for (int k = 0; k < N; k++) begin
      prod = PW'($signed(a_row[k*W +: W])) * PW'($signed(b_col[k*W +: W]));
      acc  = acc + ACC_W'(prod);
    end
  end

  always_comb begin
    oor  = (acc > MAX_V) || (acc < MIN_V);
    elem = acc[W-1:0];
    if (sat_mode && oor) elem = acc[ACC_W-1] ? MIN_V[W-1:0] : MAX_V[W-1:0];
  end

endmodule

// File: rtl/matrix_mult_param.sv
// NxN signed matrix multiplier: latches A/B on start, writes one row of C per cycle.
module matrix_mult_param
  import matrix_pkg::*;
#(
  parameter int unsigned N = 5,
  parameter int unsigned W = 8
) (
  input logic          clock,
  input logic          reset,
  matrix_mult_param_if.slave bus
);
  localparam int unsigned    RW   = clog2_min1(N);
  localparam logic [RW-1:0]  LAST = RW'(N - 1);

  state_t             state_q, state_d;
  logic [N*N*W-1:0]   a_q, a_d, b_q, b_d, c_q, c_d;
  logic               sat_q, sat_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ovf_q, ovf_d;
  logic [RW-1:0]      row_q, row_d;

  logic [N*W-1:0]     a_row;
  logic [N*W-1:0]     b_col [N];
  logic [W-1:0]       elem  [N];
  logic [N-1:0]       oor;

  assign a_row = a_q[idx(32'(row_q), 0, N, W) +: N*W];

  // One dot-product unit per output column, all fed the current A row.
  for (genvar col = 0; col < N; col++) begin : g_col
    for (genvar k = 0; k < N; k++) begin : g_k
      assign b_col[col][k*W +: W] = b_q[idx(k, col, N, W) +: W];
    end
    matrix_dot_sat #(.N(N), .W(W)) u_dot (
      .a_row    (a_row),
      .b_col    (b_col[col]),
      .sat_mode (sat_q),
      .elem     (elem[col]),
      .oor      (oor[col])
    );
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      sat_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      sat_q   <= sat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      row_q   <= row_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = CALC;
      CALC:    if (row_q == LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    c_d    = c_q;
    sat_d  = sat_q;
    busy_d = busy_q;
    done_d = 1'b0;
    ovf_d  = ovf_q;
    row_d  = row_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d    = bus.matriz_a;
          b_d    = bus.matriz_b;
          sat_d  = bus.sat_mode;
          c_d    = '0;
          ovf_d  = 1'b0;
          busy_d = 1'b1;
          row_d  = '0;
        end
      end
      CALC: begin
        for (int c = 0; c < N; c++) c_d[idx(32'(row_q), 32'(c), N, W) +: W] = elem[c];
        ovf_d = ovf_q | (|oor);
        if (row_q == LAST) begin
          busy_d = 1'b0;
          done_d = 1'b1;
          row_d  = '0;
        end else begin
          row_d = row_q + RW'(1);
        end
      end
      default: ;
    endcase
  end

  assign bus.matriz_c = c_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_matrix_mult_param.sv
// Bench for matrix_mult_param: 5x5/8-bit and 3x3/4-bit instances against an integer model.
module tb_matrix_mult_param;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  matrix_mult_param_if #(.N(5), .W(8)) if5 ();
  matrix_mult_param_if #(.N(3), .W(4)) if3 ();

  matrix_mult_param #(.N(5), .W(8)) u5 (.clock(clock), .reset(reset), .bus(if5));
  matrix_mult_param #(.N(3), .W(4)) u3 (.clock(clock), .reset(reset), .bus(if3));

  int errors = 0;
  int checks = 0;
  int ma [8][8];
  int mb [8][8];
  int mc [8][8];
  int e1 [8][8];
  bit m_ovf, e1_ovf;
  int busy_cnt, done_cnt, done_j;

  // Reference: exact integer dot products, then clamp or two's-complement wrap.
  task automatic model(input int n, input int w, input bit sat);
    int lo, hi, s, v;
    lo = -(1 << (w - 1));
    hi = (1 << (w - 1)) - 1;
    m_ovf = 1'b0;
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++) begin
        s = 0;
        for (int k = 0; k < n; k++) s += ma[r][k] * mb[k][c];
        if (s < lo || s > hi) m_ovf = 1'b1;
        if (sat) v = (s < lo) ? lo : ((s > hi) ? hi : s);
        else begin
          v = s & ((1 << w) - 1);
          if (v > hi) v -= (1 << w);
        end
        mc[r][c] = v;
      end
  endtask

  task automatic fill(input int va, input int vb);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        ma[r][c] = va;
        mb[r][c] = vb;
      end
  endtask

  task automatic drive5(input bit sat);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        if5.matriz_a[(r*5+c)*8 +: 8] = 8'(ma[r][c]);
        if5.matriz_b[(r*5+c)*8 +: 8] = 8'(mb[r][c]);
      end
    if5.sat_mode = sat;
  endtask

  task automatic drive3(input bit sat);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        if3.matriz_a[(r*3+c)*4 +: 4] = 4'(ma[r][c]);
        if3.matriz_b[(r*3+c)*4 +: 4] = 4'(mb[r][c]);
      end
    if3.sat_mode = sat;
  endtask

  function automatic int diff5();
    int d = 0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        if (int'($signed(if5.matriz_c[(r*5+c)*8 +: 8])) != mc[r][c]) d++;
    return d;
  endfunction

  function automatic int diff3(input bit use_first);
    int d = 0;
    int e;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        e = use_first ? e1[r][c] : mc[r][c];
        if (int'($signed(if3.matriz_c[(r*3+c)*4 +: 4])) != e) d++;
      end
    return d;
  endfunction

  // Pulse start for one edge; returns at the falling edge right after the accept edge.
  task automatic start5();
    @(negedge clock);
    if5.start = 1'b1;
    @(negedge clock);
    if5.start = 1'b0;
  endtask

  task automatic observe5(input int ncyc);
    busy_cnt = 0;
    done_cnt = 0;
    done_j   = 0;
    for (int j = 1; j <= ncyc; j++) begin
      if (j > 1) @(negedge clock);
      if (if5.busy) busy_cnt++;
      if (if5.done) begin
        done_cnt++;
        if (done_j == 0) done_j = j;
      end
    end
  endtask

  task automatic test_reset();
    checks++; if (if5.matriz_c !== '0) begin errors++; $display("FAIL reset_c5 got=%h want=0", if5.matriz_c); end
    checks++; if ({if5.busy, if5.done, if5.overflow} !== 3'b000) begin errors++; $display("FAIL reset_flags5 got=%b want=000", {if5.busy, if5.done, if5.overflow}); end
    checks++; if (if3.matriz_c !== '0) begin errors++; $display("FAIL reset_c3 got=%h want=0", if3.matriz_c); end
    checks++; if ({if3.busy, if3.done, if3.overflow} !== 3'b000) begin errors++; $display("FAIL reset_flags3 got=%b want=000", {if3.busy, if3.done, if3.overflow}); end
  endtask

  task automatic test_identity();
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        ma[r][c] = (r == c) ? 1 : 0;
        mb[r][c] = r * 5 + c - 12;
      end
    model(5, 8, 1'b0);
    drive5(1'b0);
    start5();
    observe5(12);
    checks++; if (busy_cnt != 5) begin errors++; $display("FAIL ident_busy_cycles got=%0d want=5", busy_cnt); end
    checks++; if (done_j != 6) begin errors++; $display("FAIL ident_done_latency got=%0d want=6", done_j); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL ident_done_pulses got=%0d want=1", done_cnt); end
    checks++; if (diff5() != 0) begin errors++; $display("FAIL ident_c bad_elems=%0d want=0", diff5()); end
    checks++; if (if5.overflow !== m_ovf) begin errors++; $display("FAIL ident_ovf got=%b want=%b", if5.overflow, m_ovf); end
  endtask

  task automatic test_overflow(input int va, input int vb, input string tag);
    fill(va, vb);
    for (int s = 0; s < 2; s++) begin
      model(5, 8, s[0]);
      drive5(s[0]);
      start5();
      observe5(8);
      checks++; if (diff5() != 0) begin errors++; $display("FAIL %s_c sat=%0d bad_elems=%0d want=0 elem00=%0d want=%0d", tag, s, diff5(), $signed(if5.matriz_c[7:0]), mc[0][0]); end
      checks++; if (if5.overflow !== m_ovf) begin errors++; $display("FAIL %s_ovf sat=%0d got=%b want=%b", tag, s, if5.overflow, m_ovf); end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL %s_done sat=%0d got=%0d want=1", tag, s, done_cnt); end
    end
  endtask

  task automatic test_random();
    bit sat;
    for (int it = 0; it < 4; it++) begin
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 5; c++) begin
          ma[r][c] = int'($urandom_range(255)) - 128;
          mb[r][c] = int'($urandom_range(255)) - 128;
        end
      sat = 1'($urandom_range(1));
      model(5, 8, sat);
      drive5(sat);
      start5();
      observe5(8);
      checks++; if (diff5() != 0) begin errors++; $display("FAIL rand_c it=%0d bad_elems=%0d want=0", it, diff5()); end
      checks++; if (if5.overflow !== m_ovf) begin errors++; $display("FAIL rand_ovf it=%0d got=%b want=%b", it, if5.overflow, m_ovf); end
    end
  endtask

  task automatic test_latch();
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        ma[r][c] = int'($urandom_range(255)) - 128;
        mb[r][c] = int'($urandom_range(255)) - 128;
      end
    model(5, 8, 1'b1);
    drive5(1'b1);
    start5();
    done_cnt = 0;
    for (int j = 1; j <= 14; j++) begin
      if (j > 1) @(negedge clock);
      if (j == 2) begin
        if5.matriz_a = '0;
        if5.sat_mode = 1'b0;
        if5.start    = 1'b1;
      end
      if (j == 4) if5.start = 1'b0;
      if (if5.done) done_cnt++;
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL latch_done_pulses got=%0d want=1", done_cnt); end
    checks++; if (diff5() != 0) begin errors++; $display("FAIL latch_c bad_elems=%0d want=0", diff5()); end
    checks++; if (if5.overflow !== m_ovf) begin errors++; $display("FAIL latch_ovf got=%b want=%b", if5.overflow, m_ovf); end
  endtask

  task automatic test_reset_midop();
    fill(16, 16);
    drive5(1'b0);
    start5();
    @(negedge clock);
    @(negedge clock);
    checks++; if ({if5.busy, if5.overflow} !== 2'b11) begin errors++; $display("FAIL midop_pre got=%b want=11", {if5.busy, if5.overflow}); end
    reset = 1'b1;
    #1;
    checks++; if (if5.matriz_c !== '0) begin errors++; $display("FAIL midop_c got=%h want=0", if5.matriz_c); end
    checks++; if ({if5.busy, if5.done, if5.overflow} !== 3'b000) begin errors++; $display("FAIL midop_flags got=%b want=000", {if5.busy, if5.done, if5.overflow}); end
    @(negedge clock);
    reset = 1'b0;
    observe5(10);
    checks++; if (done_cnt != 0 || busy_cnt != 0) begin errors++; $display("FAIL midop_after done=%0d busy=%0d want=0,0", done_cnt, busy_cnt); end
  endtask

  task automatic test_back_to_back();
    int first_j, second_j;
    fill(7, 7);
    model(3, 4, 1'b1);
    e1 = mc;
    e1_ovf = m_ovf;
    drive3(1'b1);
    @(negedge clock);
    if3.start = 1'b1;
    @(negedge clock);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        ma[r][c] = (r == 0) ? -8 : int'($urandom_range(15)) - 8;
        mb[r][c] = (c == 0) ? 7 : int'($urandom_range(15)) - 8;
      end
    model(3, 4, 1'b1);
    drive3(1'b1);
    done_cnt = 0;
    first_j  = 0;
    second_j = 0;
    for (int j = 1; j <= 12; j++) begin
      if (j > 1) @(negedge clock);
      if (j == 5) if3.start = 1'b0;
      if (if3.done) begin
        done_cnt++;
        if (first_j == 0) first_j = j;
        else if (second_j == 0) second_j = j;
      end
      if (j == 4) begin
        checks++; if (diff3(1'b1) != 0) begin errors++; $display("FAIL b2b_c1 bad_elems=%0d want=0", diff3(1'b1)); end
        checks++; if (if3.overflow !== e1_ovf) begin errors++; $display("FAIL b2b_ovf1 got=%b want=%b", if3.overflow, e1_ovf); end
      end
      if (j == 8) begin
        checks++; if (diff3(1'b0) != 0) begin errors++; $display("FAIL b2b_c2 bad_elems=%0d want=0", diff3(1'b0)); end
        checks++; if (int'($signed(if3.matriz_c[3:0])) != -8) begin errors++; $display("FAIL b2b_neg_clamp got=%0d want=-8", $signed(if3.matriz_c[3:0])); end
      end
    end
    checks++; if (done_cnt != 2) begin errors++; $display("FAIL b2b_done_pulses got=%0d want=2", done_cnt); end
    checks++; if (first_j != 4 || second_j != 8) begin errors++; $display("FAIL b2b_done_spacing got=%0d,%0d want=4,8", first_j, second_j); end
  endtask

  initial begin
    reset = 1'b1;
    if5.start = 1'b0; if5.sat_mode = 1'b0; if5.matriz_a = '0; if5.matriz_b = '0;
    if3.start = 1'b0; if3.sat_mode = 1'b0; if3.matriz_a = '0; if3.matriz_b = '0;
    @(negedge clock);
    @(negedge clock);
    test_reset();
    reset = 1'b0;
    test_identity();
    test_overflow(16, 16, "pos");
    test_overflow(-128, 127, "neg");
    test_random();
    test_latch();
    test_reset_midop();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/matrix_mult_param.md
Name: matrix_mult_param

Overview:
- Parametrised signed NxN integer matrix multiplier, C = A x B; next generation of the fixed 5x5 8-bit row-per-cycle multiplier.
- Adds a start/busy/done handshake, input latching and selectable wrap or saturate output.
- Adds a sticky overflow flag and asynchronous reset.
- Sits between the matrix register file/bus interface and the result buffer of the coprocessor datapath.

Parameters:
- N, 5, matrix dimension (rows = cols); legal range 2..8.
- W, 8, signed element width in bits; legal range 4..16.

Ports:
- clock  in  1  single system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request a multiply; sampled only in IDLE.
- sat_mode  in  1  0 = wrap (keep low W bits), 1 = saturate; latched at accept.
- matriz_a  in  N*N*W  flat signed A; element (r,c) at bits [(r*N+c)*W +: W].
- matriz_b  in  N*N*W  flat signed B; same packing as A.
- matriz_c  out  N*N*W  registered result C; same packing.
- busy  out  1  high from the edge after accept until the last row is written.
- done  out  1  one-cycle pulse when C is complete.
- overflow  out  1  sticky; set if any element's exact sum is outside the signed W-bit range.

Behaviour:
- Async reset sets matriz_c=0, busy=0, done=0, overflow=0, row=0 and state=IDLE immediately, independent of clock.
- States:
  - IDLE: start=1 at an edge is an accept. It latches A, B and sat_mode into internal registers, clears matriz_c to 0 and clears overflow. It then sets busy=1 and row=0, and goes to CALC.
  - CALC: each edge computes row `row` (all N columns in parallel) and writes it into matriz_c. row then increments.
  - When row==N-1 is written: busy<=0, done<=1, row<=0, state<=IDLE.
- done is high for exactly one cycle and returns to 0 on the next edge.
- Latency: accept at edge k; rows written at edges k+1..k+N; done=1 during the cycle after edge k+N.
- Arithmetic:
  - Each product is a signed WxW -> 2W multiply.
  - The dot product is accumulated at full precision, ACC_W = 2W + ceil(log2(N)). No intermediate truncation.
- Output conversion per element:
  - Wrap mode: low W bits of the exact sum.
  - Saturate mode: clamp to [-2^(W-1), 2^(W-1)-1].
- overflow is set during CALC if any exact sum is outside the W-bit range, in either mode. It holds until the next accept or reset.
- Changes on matriz_a, matriz_b or sat_mode while busy have no effect on the result; only latched copies are used.
- start while busy=1 is ignored (no queueing).
- start=1 in the cycle where done=1 is accepted, because the FSM is already in IDLE. done still pulses for its single cycle.
- Holding start=1 continuously produces back-to-back operations, each N+1 cycles apart.
- Reset asserted mid-operation aborts it: no done pulse, and outputs take their reset values.
- matriz_c rows not yet written during CALC read 0.
- matriz_c holds the final result stable until the next accept.

Decomposition:
- Package matrix_pkg holds:
  - the ACC_W width function;
  - a clog2 helper for the row counter width (minimum 1 bit);
  - the FSM state enum {IDLE, CALC};
  - the flat-bus element index function idx(r,c,N,W).
- Sub-module matrix_dot_sat (parameters N, W) is instantiated N times, once per output column.
  - Inputs: one latched A row and one B column.
  - Outputs: the W-bit converted element and a per-element out-of-range bit.
  - Purely combinational. The parent owns all registers, the FSM and the sticky OR of the out-of-range bits.

Test Plan:
- Identity (N=5, W=8): A=I, B(r,c)=r*5+c-12, sat_mode=0. Requires C==B, overflow=0, done pulse exactly 5 cycles after the accept edge, busy high for 5 cycles.
- Positive overflow: all A=B=16, so each sum is 1280. With sat_mode=0, C is all 0x00 and overflow=1. With sat_mode=1, C is all 0x7F (127) and overflow=1.
- Negative overflow: all A=-128, all B=127, so each sum is -81280. Requires C all 0x80 in both modes, with overflow=1.
- Latching and ignore: accept, then drive A=0 and pulse start during cycles 2-3. Requires the result to match the original A and only one done pulse.
- Reset mid-op: assert reset on the 3rd CALC cycle. Requires matriz_c=0, busy=0, done=0 and overflow=0 immediately, with no done pulse afterwards.
- Back-to-back and alternate parameters (N=3, W=4): start held high for two operations. Requires done pulses 4 cycles apart, correct C for both, and 4-bit clamping to [-8,7] in saturate mode.
